// File: rtl/fft_sdf_bf_stage16_if.sv
// Sample/twiddle bus into the stage-16 SDF butterfly and its result bus out.
// The master side is the upstream twiddle ROM plus sample source.
interface fft_sdf_bf_stage16_if #(
    parameter int DW = 24
);
    logic                 in_valid;
    logic signed [DW-1:0] din_r;
    logic signed [DW-1:0] din_i;
    logic [1:0]           state;
    logic signed [DW-1:0] w_r;
    logic signed [DW-1:0] w_i;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;

    modport master (
        output in_valid, din_r, din_i, state, w_r, w_i,
        input  out_valid, dout_r, dout_i
    );

    modport slave (
        input  in_valid, din_r, din_i, state, w_r, w_i,
        output out_valid, dout_r, dout_i
    );
endinterface

// File: rtl/fft_sdf_bf_stage16.sv
// Radix-2 SDF butterfly stage with a 16-sample feedback delay line (512-pt FFT).
// Circular buffer: the slot under the pointer holds the entry from DEPTH advances ago.
module fft_sdf_bf_stage16 #(
    parameter int DW    = 24,
    parameter int DEPTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_sdf_bf_stage16_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int MW = 2 * DW + 1;

    typedef enum logic [1:0] {
        PH_FILL = 2'd0,
        PH_BFLY = 2'd1,
        PH_TWID = 2'd2,
        PH_RSVD = 2'd3
    } phase_e;

    logic signed [DW-1:0] mem_r_q [DEPTH];
    logic signed [DW-1:0] mem_i_q [DEPTH];
    logic [PW-1:0]        ptr_q;
    logic                 out_valid_q;
    logic signed [DW-1:0] dout_r_q;
    logic signed [DW-1:0] dout_i_q;

    phase_e               phase;
    logic signed [DW-1:0] head_r;
    logic signed [DW-1:0] head_i;
    logic signed [MW-1:0] prod_r_full;
    logic signed [MW-1:0] prod_i_full;
    logic signed [DW-1:0] push_r_d;
    logic signed [DW-1:0] push_i_d;
    logic signed [DW-1:0] res_r_d;
    logic signed [DW-1:0] res_i_d;
    logic                 emit_d;

    assign phase  = phase_e'(bus.state);
    assign head_r = mem_r_q[ptr_q];
    assign head_i = mem_i_q[ptr_q];

    // Full-width products; the shift is arithmetic so the scaling floors toward -inf.
    assign prod_r_full = MW'(head_r) * MW'(bus.w_r) - MW'(head_i) * MW'(bus.w_i);
    assign prod_i_full = MW'(head_r) * MW'(bus.w_i) + MW'(head_i) * MW'(bus.w_r);

    always_comb begin
        push_r_d = bus.din_r;
        push_i_d = bus.din_i;
        res_r_d  = dout_r_q;
        res_i_d  = dout_i_q;
        emit_d   = 1'b0;
        case (phase)
            PH_BFLY: begin
                res_r_d  = head_r + bus.din_r;
                res_i_d  = head_i + bus.din_i;
                push_r_d = head_r - bus.din_r;
                push_i_d = head_i - bus.din_i;
                emit_d   = 1'b1;
            end
            PH_TWID: begin
                res_r_d = DW'(prod_r_full >>> FRAC);
                res_i_d = DW'(prod_i_full >>> FRAC);
                emit_d  = 1'b1;
            end
            default: begin
                emit_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r_q[k] <= '0;
                mem_i_q[k] <= '0;
            end
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
                mem_r_q[ptr_q] <= push_r_d;
                mem_i_q[ptr_q] <= push_i_d;
                ptr_q          <= ptr_q + PW'(1);
                out_valid_q    <= emit_d;
                dout_r_q       <= res_r_d;
                dout_i_q       <= res_i_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout_r    = dout_r_q;
    assign bus.dout_i    = dout_i_q;
endmodule

// File: tb/tb_fft_sdf_bf_stage16.sv
// Directed bench for fft_sdf_bf_stage16: ROM-sequenced frames checked by a
// scoreboard queue plus the fixed values from the impulse/DC/twiddle cases.
module tb_fft_sdf_bf_stage16;
    localparam int DW = 24;
    typedef logic signed [DW-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_sdf_bf_stage16_if #(.DW(DW)) bus ();

    fft_sdf_bf_stage16 #(.DW(DW), .DEPTH(16), .FRAC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    total = 0;
    int    bad   = 0;
    word_t expQR[$], expQI[$];
    word_t pushR[$], pushI[$];
    word_t logR[$],  logI[$];
    word_t frameR[80], frameI[80];
    word_t lastR, lastI;
    int    advCnt;
    bit    romMode;
    bit    monEn;
    logic [1:0] forcedState;
    logic  expValid;
    logic  expValidQ;

    function automatic word_t twR(input int k);
        real a;
        a = 2.0 * 3.14159265358979 * k / 32.0;
        return word_t'($rtoi($floor(256.0 * $cos(a) + 0.5)));
    endfunction

    function automatic word_t twI(input int k);
        real a;
        a = 2.0 * 3.14159265358979 * k / 32.0;
        return word_t'($rtoi($floor(-256.0 * $sin(a) + 0.5)));
    endfunction

    task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        advCnt = 0;
        pushR.delete();
        pushI.delete();
        logR.delete();
        logI.delete();
    endtask

    // Reference: head = entry pushed 16 advances ago (zero right after reset/frame start).
    task automatic applyStimulus(input bit valid, input word_t xr, input word_t xi);
        word_t dr, di, wr, wi, er, ei;
        logic [1:0] st;
        longint pr, pi;
        int n;
        wr = word_t'($urandom);
        wi = word_t'($urandom);
        st = 2'($urandom_range(0, 3));
        if (valid) begin
            n = advCnt;
            if (romMode) st = (n < 16) ? 2'd0 : ((((n - 16) / 16) % 2 == 0) ? 2'd1 : 2'd2);
            else         st = forcedState;
            if (st == 2'd2) begin
                wr = twR(n % 16);
                wi = twI(n % 16);
            end
            dr = (n >= 16) ? pushR[n-16] : word_t'(0);
            di = (n >= 16) ? pushI[n-16] : word_t'(0);
            if (st == 2'd1) begin
                er = dr + xr;
                ei = di + xi;
                expQR.push_back(er);
                expQI.push_back(ei);
                pushR.push_back(dr - xr);
                pushI.push_back(di - xi);
            end else begin
                if (st == 2'd2) begin
                    pr = longint'(dr) * longint'(wr) - longint'(di) * longint'(wi);
                    pi = longint'(dr) * longint'(wi) + longint'(di) * longint'(wr);
                    expQR.push_back(word_t'(pr >>> 8));
                    expQI.push_back(word_t'(pi >>> 8));
                end
                pushR.push_back(xr);
                pushI.push_back(xi);
            end
            advCnt++;
        end
        bus.in_valid = valid;
        bus.din_r    = valid ? xr : word_t'($urandom);
        bus.din_i    = valid ? xi : word_t'($urandom);
        bus.state    = st;
        bus.w_r      = wr;
        bus.w_i      = wi;
        expValid     = valid && (st == 2'd1 || st == 2'd2);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        expValid     = 1'b0;
        #1;
        checkOutput("rst_out_valid", word_t'(bus.out_valid), word_t'(0));
        checkOutput("rst_dout_r", bus.dout_r, word_t'(0));
        checkOutput("rst_dout_i", bus.dout_i, word_t'(0));
        expQR.delete();
        expQI.delete();
        lastR = '0;
        lastI = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clearFrame();
        foreach (frameR[k]) begin
            frameR[k] = '0;
            frameI[k] = '0;
        end
    endtask

    task automatic applyFrame(input int len, input int gapA, input int lenA,
                              input int gapB, input int lenB, input int resetAt, input bit rndGap);
        resetModel();
        for (int n = 0; n < len; n++) begin
            if (n == resetAt) begin
                doReset();
                return;
            end
            applyStimulus(1'b1, frameR[n], frameI[n]);
            if (n == gapA) repeat (lenA) applyStimulus(1'b0, '0, '0);
            if (n == gapB) repeat (lenB) applyStimulus(1'b0, '0, '0);
            if (rndGap && $urandom_range(0, 3) == 0) applyStimulus(1'b0, '0, '0);
        end
        repeat (2) applyStimulus(1'b0, '0, '0);
        checkOutput("sb_empty", word_t'(expQR.size()), word_t'(0));
    endtask

    task automatic checkDc(input string tag);
        checkOutput({tag, "_count"}, word_t'(logR.size()), word_t'(32));
        for (int k = 0; k < 32 && k < logR.size(); k++) begin
            checkOutput($sformatf("%s_r[%0d]", tag, k), logR[k], (k < 16) ? word_t'(200) : word_t'(0));
            checkOutput($sformatf("%s_i[%0d]", tag, k), logI[k], word_t'(0));
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) expValidQ <= 1'b0;
        else        expValidQ <= expValid;
    end

    // Output side of the scoreboard: valid results pop the queue, idle cycles must hold.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && monEn) begin
            checkOutput("out_valid", word_t'(bus.out_valid), word_t'(expValidQ));
            if (bus.out_valid === 1'b1) begin
                if (expQR.size() == 0) begin
                    total++;
                    bad++;
                    $error("[TB] FAIL sb_underflow: observed=unexpected output expected=no output");
                end else begin
                    lastR = expQR.pop_front();
                    lastI = expQI.pop_front();
                    checkOutput("dout_r", bus.dout_r, lastR);
                    checkOutput("dout_i", bus.dout_i, lastI);
                    logR.push_back(bus.dout_r);
                    logI.push_back(bus.dout_i);
                end
            end else begin
                checkOutput("hold_r", bus.dout_r, lastR);
                checkOutput("hold_i", bus.dout_i, lastI);
            end
        end
    end

    initial begin
        word_t v;
        rst_n        = 1'b0;
        monEn        = 1'b0;
        romMode      = 1'b1;
        forcedState  = 2'd0;
        expValid     = 1'b0;
        lastR        = '0;
        lastI        = '0;
        bus.in_valid = 1'b0;
        bus.din_r    = '0;
        bus.din_i    = '0;
        bus.state    = 2'd0;
        bus.w_r      = '0;
        bus.w_i      = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", word_t'(bus.out_valid), word_t'(0));
        checkOutput("reset_dout_r", bus.dout_r, word_t'(0));
        checkOutput("reset_dout_i", bus.dout_i, word_t'(0));
        rst_n = 1'b1;
        monEn = 1'b1;

        // Impulse at sample 0.
        clearFrame();
        frameR[0] = 256;
        applyFrame(48, -1, 0, -1, 0, -1, 1'b0);
        checkOutput("impulse_count", word_t'(logR.size()), word_t'(32));
        for (int k = 0; k < 32 && k < logR.size(); k++) begin
            checkOutput($sformatf("impulse_r[%0d]", k), logR[k], (k == 0 || k == 16) ? word_t'(256) : word_t'(0));
            checkOutput($sformatf("impulse_i[%0d]", k), logI[k], word_t'(0));
        end

        // DC, 32 samples of 100.
        clearFrame();
        for (int k = 0; k < 32; k++) frameR[k] = 100;
        applyFrame(48, -1, 0, -1, 0, -1, 1'b0);
        checkDc("dc");

        // Twiddle path, impulse at sample 1.
        clearFrame();
        frameR[1] = 256;
        applyFrame(48, -1, 0, -1, 0, -1, 1'b0);
        checkOutput("twid_bf_r", logR[1], word_t'(256));
        checkOutput("twid_bf_i", logI[1], word_t'(0));
        checkOutput("twid_mul_r", logR[17], word_t'(251));
        checkOutput("twid_mul_i", logI[17], word_t'(-50));

        // Negative value: products floor toward -inf.
        clearFrame();
        frameR[1] = -1;
        applyFrame(48, -1, 0, -1, 0, -1, 1'b0);
        checkOutput("neg_bf_r", logR[1], word_t'(-1));
        checkOutput("neg_bf_i", logI[1], word_t'(0));
        checkOutput("neg_mul_r", logR[17], word_t'(-1));
        checkOutput("neg_mul_i", logI[17], word_t'(0));

        // DC with in_valid gaps.
        clearFrame();
        for (int k = 0; k < 32; k++) frameR[k] = 100;
        applyFrame(48, 20, 3, 40, 2, -1, 1'b0);
        checkDc("gap");

        // Reset mid-frame, then a fresh DC frame.
        applyFrame(48, -1, 0, -1, 0, 24, 1'b0);
        applyFrame(48, -1, 0, -1, 0, -1, 1'b0);
        checkDc("post_rst");

        // Reset must clear the delay line: butterfly straight after release sees zero heads.
        applyFrame(48, -1, 0, -1, 0, 20, 1'b0);
        resetModel();
        romMode     = 1'b0;
        forcedState = 2'd1;
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, word_t'(3), '0);
        forcedState = 2'd3;
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, word_t'(k * 1000 - 5000), word_t'(k));
        forcedState = 2'd1;
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, word_t'(7), '0);
        repeat (2) applyStimulus(1'b0, '0, '0);
        checkOutput("forced_count", word_t'(logR.size()), word_t'(32));
        for (int k = 0; k < 16 && 16 + k < logR.size(); k++) begin
            checkOutput($sformatf("clr_r[%0d]", k), logR[k], word_t'(3));
            v = word_t'(k * 1000 - 5000 + 7);
            checkOutput($sformatf("rsvd_r[%0d]", k), logR[16+k], v);
            checkOutput($sformatf("rsvd_i[%0d]", k), logI[16+k], word_t'(k));
        end
        romMode = 1'b1;

        // Full-range random stream over two butterfly/twiddle rounds with random gaps.
        for (int k = 0; k < 80; k++) begin
            frameR[k] = (k < 64) ? word_t'($urandom) : word_t'(0);
            frameI[k] = (k < 64) ? word_t'($urandom) : word_t'(0);
        end
        applyFrame(80, -1, 0, -1, 0, -1, 1'b1);
        checkOutput("rand_count", word_t'(logR.size()), word_t'(64));

        monEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_sdf_bf_stage16.md
Name: fft_sdf_bf_stage16

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage with a 16-deep feedback delay line, for the 512-point FFT pipeline.
- It sits directly downstream of the stage-16 twiddle ROM. The ROM's state and twiddle outputs are combinationally aligned with the sample on din.
- The stage performs the add/subtract butterfly and the complex twiddle multiply for the 32-sample sub-frame. It forwards results to the next stage.

Parameters:
- DW, 24, signed data and twiddle word width (real and imaginary each).
- DEPTH, 16, feedback delay-line length in samples; half of the 32-sample butterfly span.
- FRAC, 8, twiddle fraction bits; 256 represents +1.0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample on din_r/din_i is valid; the stage advances only when this is high.
- din_r  input  DW  signed real input sample.
- din_i  input  DW  signed imaginary input sample.
- state  input  2  stage phase from the twiddle ROM: 0 = fill, 1 = butterfly, 2 = twiddle-multiply, 3 = reserved.
- w_r  input  DW  signed twiddle, real part, Q(DW-FRAC).FRAC.
- w_i  input  DW  signed twiddle, imaginary part.
- out_valid  output  1  dout is valid this cycle.
- dout_r  output  DW  signed real result.
- dout_i  output  DW  signed imaginary result.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: all DEPTH delay entries = 0; out_valid = 0; dout_r = dout_i = 0; delay-line pointer = 0.
- Delay line: DEPTH x (2*DW) storage, built as a circular buffer or shift register.
  - Head d = d_r + j*d_i is the entry written exactly DEPTH advancing cycles earlier.
  - Each advancing cycle reads d and writes one new entry.
- Advancing cycle: any rising edge with in_valid = 1. Let x = din.
  - state 0 (and reserved 3): push x; out_valid <= 0; dout holds.
  - state 1: dout <= d + x; push d - x; out_valid <= 1.
  - state 2: dout <= d * w; push x; out_valid <= 1.
- Complex product: re = d_r*w_r - d_i*w_i; im = d_r*w_i + d_i*w_r.
  - Full 2*DW+1-bit intermediates.
  - Arithmetic shift right by FRAC (floor, no rounding), then keep the low DW bits.
- Add/subtract: DW-bit two's-complement, wrap on overflow, no saturation, no growth. Headroom is the upstream stages' responsibility.
- Non-advancing cycle (in_valid = 0): delay line and pointer frozen; out_valid <= 0; dout_r/dout_i hold their last value.
- Latency: a result appears on dout exactly 1 cycle after its advancing cycle.
  - Within a continuous stream, the butterfly for input pair (k, k+16) produces sum at input k+16 and difference*twiddle at input k+32.
- Frame sequencing (supplied by the ROM):
  - First 16 advancing samples are state 0.
  - Thereafter state alternates: 16 samples of state 1, then 16 of state 2.
  - A state-2 block emits the previous block's differences while loading the next sub-frame.
- Flush: to drain the final differences, upstream drives 16 extra advancing cycles with zero data.
- State change between consecutive advancing cycles: no bubble. Each cycle uses the state present on that cycle only.
- in_valid gaps anywhere, including mid-block: results are bit-identical to an ungapped stream; only out_valid timing shifts.
- Reset mid-operation: immediately clears everything to reset values. No partial output after release. The first post-reset advancing cycle is treated per the state input.
- The twiddle inputs are sampled only in state 2. In states 0, 1 and 3 they are don't-care.

Test Plan:
- Impulse: din_r = 256 at sample 0, every other sample 0, for 32 samples plus 16 zero flush samples; ROM-driven state. Required: out_valid high for 32 cycles starting 1 cycle after sample 16. dout_r = 256 on the 1st and 17th valid outputs; all other dout values 0.
- DC: din_r = 100 for samples 0..31, then 16 zeros. Required: first 16 valid outputs dout_r = 200, dout_i = 0; next 16 outputs are 0.
- Twiddle: din_r = 256 at sample 1 only, zeros elsewhere.
  - 2nd butterfly output: (256, 0).
  - 2nd twiddle output, with w = (251, -50): dout_r = 251, dout_i = -50.
- Negative floor: din_r = -1 at sample 1, zeros elsewhere.
  - 2nd butterfly output: (-1, 0).
  - 2nd twiddle output, with w = (251, -50): dout_r = -1 (-251 >>> 8), dout_i = 0 (50 >>> 8).
- Gaps: repeat the DC test with in_valid low for 3 cycles after sample 20 and 2 cycles after sample 40. Required: out_valid low in those cycles, dout held, and the valid-output sequence identical to the DC test.
- Reset: assert rst_n low at sample 24 of the DC test. Required: out_valid = 0, dout = 0 and delay line zero immediately. After release with fresh ROM state, a new DC frame reproduces the DC-test results.
